// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-legality helper for the load/store unit.
package lsu_pkg;

    // Number of implemented data_memory words; word index 127 does not exist.
    localparam int MEM_WORDS_DEFAULT = 127;

    // RISC-V funct3 encodings for the load/store widths.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Stores only have signed widths; loads also have the unsigned variants.
    function automatic logic funct3_legal(input logic is_write, input logic [2:0] f3);
        if (is_write) begin
            return f3 inside {F3_B, F3_H, F3_W};
        end
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends load data, and merges sub-word store data into a word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half and build both the load result and the merged store word.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        byte_sel   = word[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase

        case (funct3)
            F3_B: begin
                store_word = word;
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = word;
                store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end: turns LB/LH/LW/LBU/LHU/SB/SH/SW into
// word accesses on data_memory, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic [DATA_WIDTH-1:0] mem_readData
);

    localparam logic [ADDR_WIDTH:0] WORD_LIMIT = MEM_WORDS[ADDR_WIDTH:0];

    lsu_state_e             state_q;
    lsu_state_e             state_d;
    logic [ADDR_WIDTH+1:0]  addr_q;
    logic [2:0]             funct3_q;
    logic                   write_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   req_err;
    logic [ADDR_WIDTH-1:0]  req_index;
    logic [DATA_WIDTH-1:0]  load_data;
    logic [DATA_WIDTH-1:0]  store_word;

    assign req_index = bus.req_addr[ADDR_WIDTH+1:2];

    // Reject illegal widths, misalignment and addresses outside the implemented words.
    always_comb begin
        req_err = 1'b0;
        if (!funct3_legal(bus.req_write, bus.req_funct3)) begin
            req_err = 1'b1;
        end
        if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) begin
            req_err = 1'b1;
        end
        if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
        if (bus.req_addr[31:ADDR_WIDTH+2] != '0) begin
            req_err = 1'b1;
        end
        if ({1'b0, req_index} >= WORD_LIMIT) begin
            req_err = 1'b1;
        end
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .word       (mem_readData),
        .wdata      (data_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register; reset drops any in-flight request and its response.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory/handshake control decoded from state and latched request.
    always_comb begin
        state_d        = state_q;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        mem_address    = '0;
        mem_writeData  = '0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_write && bus.req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                memRead     = 1'b1;
                mem_address = addr_q[ADDR_WIDTH+1:2];
                state_d     = write_q ? WRITE : RESP;
            end
            WRITE: begin
                memWrite      = 1'b1;
                mem_address   = addr_q[ADDR_WIDTH+1:2];
                mem_writeData = data_q;
                state_d       = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, store-data merge and response data; response fields hold between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q         <= '0;
            funct3_q       <= F3_B;
            write_q        <= 1'b0;
            data_q         <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
                        funct3_q <= bus.req_funct3;
                        write_q  <= bus.req_write;
                        data_q   <= bus.req_wdata;
                        if (req_err) begin
                            bus.resp_rdata <= '0;
                            bus.resp_err   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        data_q <= store_word;
                    end else begin
                        bus.resp_rdata <= load_data;
                        bus.resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [6:0]  mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory model: readData changes at negedge, writes commit at posedge.
    logic [31:0] mem [0:126];
    always @(negedge clk) mem_readData <= (mem_address < 7'd127) ? mem[mem_address] : 32'h0;
    always @(posedge clk) if (memWrite && mem_address < 7'd127) mem[mem_address] <= mem_writeData;

    int vectors = 0;
    int miscompares = 0;

    // Results of the last request.
    int          r_lat, r_rd, r_wr, seen_wr, seen_resp;
    logic [6:0]  r_wr_addr;
    logic [31:0] r_wr_data, r_rdata;
    logic        r_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at negedge and release it just after the accept edge.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Issue a request and record in which cycle after accept each event appears.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(wr, f3, addr, wd);
        r_lat = 0; r_rd = 0; r_wr = 0; r_wr_addr = '0; r_wr_data = '0; r_rdata = '0; r_err = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (memRead && r_rd == 0) r_rd = c;
            if (memWrite && r_wr == 0) begin
                r_wr = c; r_wr_addr = mem_address; r_wr_data = mem_writeData;
            end
            if (bus.resp_valid) begin
                r_lat = c; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, f3, addr, 32'h0);
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_err"}, 32'(r_err), 32'd0);
        check({tag, "_lat"}, 32'(r_lat), 32'd2);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        do_req(wr, f3, addr, 32'hFFFF_FFFF);
        check({tag, "_err"}, 32'(r_err), 32'd1);
        check({tag, "_data"}, r_rdata, 32'h0);
        check({tag, "_lat"}, 32'(r_lat), 32'd1);
        check({tag, "_nomem"}, 32'(r_rd + r_wr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_ctl", {30'h0, memRead, memWrite}, 32'h0);
        check("rst_mem_addr", 32'(mem_address), 32'h0);
        check("rst_mem_wdata", mem_writeData, 32'h0);
        rst_n = 1'b1;

        // SW then LW on word 1
        do_req(1'b1, F3_W, 32'h004, 32'h1234_5678);
        check("sw_wr_cycle", 32'(r_wr), 32'd1);
        check("sw_wr_addr", 32'(r_wr_addr), 32'd1);
        check("sw_wr_data", r_wr_data, 32'h1234_5678);
        check("sw_lat", 32'(r_lat), 32'd2);
        check("sw_err", 32'(r_err), 32'd0);
        load_chk("lw4", F3_W, 32'h004, 32'h1234_5678);
        check("lw4_rd_cycle", 32'(r_rd), 32'd1);

        // Byte/half extraction and extension
        load_chk("lb5", F3_B, 32'h005, 32'h0000_0056);
        load_chk("lb7", F3_B, 32'h007, 32'h0000_0012);
        do_req(1'b1, F3_W, 32'h008, 32'h8765_4321);
        check("sw8_lat", 32'(r_lat), 32'd2);
        load_chk("lbB", F3_B, 32'h00B, 32'hFFFF_FF87);
        load_chk("lbuB", F3_BU, 32'h00B, 32'h0000_0087);
        load_chk("lhA", F3_H, 32'h00A, 32'hFFFF_8765);
        load_chk("lhuA", F3_HU, 32'h00A, 32'h0000_8765);

        // Sub-word stores via read-modify-write
        do_req(1'b1, F3_H, 32'h006, 32'hCAFE_BEEF);
        check("sh_rd_cycle", 32'(r_rd), 32'd1);
        check("sh_wr_cycle", 32'(r_wr), 32'd2);
        check("sh_wr_data", r_wr_data, 32'hBEEF_5678);
        check("sh_lat", 32'(r_lat), 32'd3);
        check("sh_rdata", r_rdata, 32'h0);
        do_req(1'b1, F3_B, 32'h004, 32'h0000_00AA);
        check("sb_lat", 32'(r_lat), 32'd3);
        load_chk("lw4_after_sb", F3_W, 32'h004, 32'hBEEF_56AA);

        // Rejected requests (previous response left rdata nonzero)
        err_chk("lw_mis", 1'b0, F3_W, 32'h002);
        err_chk("sh_mis", 1'b1, F3_H, 32'h001);
        err_chk("lw_idx127", 1'b0, F3_W, 32'h1FC);
        err_chk("f3_011", 1'b0, 3'b011, 32'h000);
        err_chk("sbu_store", 1'b1, F3_BU, 32'h004);
        err_chk("hi_addr", 1'b0, F3_W, 32'h204);
        load_chk("lw4_intact", F3_W, 32'h004, 32'hBEEF_56AA);

        // Last legal word
        do_req(1'b1, F3_W, 32'h1F8, 32'hDEAD_BEEF);
        check("sw126_err", 32'(r_err), 32'd0);
        check("sw126_addr", 32'(r_wr_addr), 32'd126);
        load_chk("lw126", F3_W, 32'h1F8, 32'hDEAD_BEEF);

        // Reset on the READ->WRITE edge of an SB
        do_req(1'b1, F3_W, 32'h010, 32'h1122_3344);
        check("sw16_lat", 32'(r_lat), 32'd2);
        issue(1'b1, F3_B, 32'h010, 32'h0000_0055);
        @(negedge clk);
        check("sb_rst_memRead", 32'(memRead), 32'd1);
        rst_n = 1'b0;
        seen_wr = 0; seen_resp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen_wr += int'(memWrite);
            seen_resp += int'(bus.resp_valid);
        end
        rst_n = 1'b1;
        check("sb_rst_nowrite", 32'(seen_wr), 32'd0);
        check("sb_rst_noresp", 32'(seen_resp), 32'd0);
        check("sb_rst_ready", 32'(bus.req_ready), 32'd1);
        load_chk("lw16_unchanged", F3_W, 32'h010, 32'h1122_3344);

        // Reset on the edge ending WRITE of an SW
        issue(1'b1, F3_W, 32'h014, 32'h0A0B_0C0D);
        @(negedge clk);
        check("sw_rst_memWrite", 32'(memWrite), 32'd1);
        rst_n = 1'b0;
        seen_resp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen_resp += int'(bus.resp_valid);
        end
        rst_n = 1'b1;
        check("sw_rst_noresp", 32'(seen_resp), 32'd0);
        load_chk("lw20_committed", F3_W, 32'h014, 32'h0A0B_0C0D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
